mips_mem_arbiter: RTL

- Shares one single-port synchronous RAM between the core's instruction-fetch port and data port.
- Replaces the separate inst ROM and data RAM pair in the CPU wrapper.
- Parametrised in data width, address depth and RAM read latency.
- Adds a req/ack handshake, byte-enable writes, per-port stall outputs and 2-way arbitration.

---
 rtl/mips_mem_arbiter_pkg.sv | 18 +
 rtl/mips_mem_arbiter_if.sv | 36 +++
 rtl/mips_mem_arbiter_rr_arb.sv | 46 ++++
 rtl/mips_mem_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types for the MIPS memory arbiter: FSM state encoding, grant encoding
// and the RAM latency counter width.
package mips_mem_pkg;

  localparam int unsigned LAT_W = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Core-side bus of the memory arbiter: instruction-fetch port and data port.
// The core drives through 'master', the arbiter responds through 'slave'.
interface mips_mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    i_req;
  logic [31:0]             i_addr;
  logic [DATA_WIDTH-1:0]   i_rdata;
  logic                    i_ack;
  logic                    i_stall;

  logic                    d_req;
  logic                    d_wen;
  logic [DATA_WIDTH/8-1:0] d_be;
  logic [31:0]             d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic [DATA_WIDTH-1:0]   d_rdata;
  logic                    d_ack;
  logic                    d_stall;

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_ack, i_stall,
    output d_req, d_wen, d_be, d_addr, d_wdata,
    input  d_rdata, d_ack, d_stall
  );

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_ack, i_stall,
    input  d_req, d_wen, d_be, d_addr, d_wdata,
    output d_rdata, d_ack, d_stall
  );

endinterface

// File: rtl/mips_mem_arbiter_rr_arb.sv
// 2-way grant logic for the memory arbiter. With MIPS_MEM_ARB_RR_EN defined a
// last-grant pointer gives round-robin; otherwise data always beats instruction.
module mips_rr_arb
  import mips_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_ireq,
  input  logic i_dreq,
  input  logic i_take,
  output logic o_valid,
  output gnt_e o_gnt
);

  assign o_valid = i_ireq | i_dreq;

`ifdef MIPS_MEM_ARB_RR_EN
  gnt_e r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= GNT_I;
    end else if (i_take) begin
      r_last <= o_gnt;
    end
  end

  // On a tie the port not served last time wins; a lone request always wins.
  always_comb begin
    o_gnt = GNT_D;
    if (i_ireq && i_dreq) begin
      o_gnt = (r_last == GNT_D) ? GNT_I : GNT_D;
    end else if (i_ireq) begin
      o_gnt = GNT_I;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst, i_take};

  always_comb begin
    o_gnt = i_dreq ? GNT_D : GNT_I;
  end
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data
// ports. Grant policy selected by MIPS_MEM_ARB_RR_EN (see mips_rr_arb).
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  mips_mem_arbiter_if.slave       bus,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RAM_LATENCY);

  state_e                r_state, w_state_d;
  gnt_e                  r_gnt, w_gnt_d;
  logic [LAT_W-1:0]      r_cnt, w_cnt_d;
  logic                  r_ram_en, w_ram_en_d;
  logic [BE_W-1:0]       r_ram_we, w_ram_we_d;
  logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_d;
  logic [DATA_WIDTH-1:0] r_ram_din, w_ram_din_d;
  logic                  r_i_ack, w_i_ack_d;
  logic                  r_d_ack, w_d_ack_d;
  logic [DATA_WIDTH-1:0] r_i_rdata, w_i_rdata_d;
  logic [DATA_WIDTH-1:0] r_d_rdata, w_d_rdata_d;

  logic w_arb_valid;
  gnt_e w_arb_gnt;
  logic w_take;
  logic w_unused;

  // Byte-offset bits and bits above the RAM depth are dropped: addresses wrap.
  assign w_unused = ^{bus.i_addr[31:ADDR_WIDTH+2], bus.i_addr[1:0],
                      bus.d_addr[31:ADDR_WIDTH+2], bus.d_addr[1:0]};

  mips_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_ireq  (bus.i_req),
    .i_dreq  (bus.d_req),
    .i_take  (w_take),
    .o_valid (w_arb_valid),
    .o_gnt   (w_arb_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_gnt      <= GNT_I;
      r_cnt      <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_i_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_gnt      <= w_gnt_d;
      r_cnt      <= w_cnt_d;
      r_ram_en   <= w_ram_en_d;
      r_ram_we   <= w_ram_we_d;
      r_ram_addr <= w_ram_addr_d;
      r_ram_din  <= w_ram_din_d;
      r_i_ack    <= w_i_ack_d;
      r_d_ack    <= w_d_ack_d;
      r_i_rdata  <= w_i_rdata_d;
      r_d_rdata  <= w_d_rdata_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_gnt_d      = r_gnt;
    w_cnt_d      = r_cnt;
    w_ram_en_d   = 1'b0;
    w_ram_we_d   = '0;
    w_ram_addr_d = r_ram_addr;
    w_ram_din_d  = r_ram_din;
    w_i_ack_d    = 1'b0;
    w_d_ack_d    = 1'b0;
    w_i_rdata_d  = r_i_rdata;
    w_d_rdata_d  = r_d_rdata;
    w_take       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_arb_valid) begin
          // The RAM command registers double as the latched copy of the request.
          w_take      = 1'b1;
          w_gnt_d     = w_arb_gnt;
          w_ram_en_d  = 1'b1;
          w_ram_din_d = bus.d_wdata;
          w_cnt_d     = LAT_LOAD;
          w_state_d   = StWait;
          if (w_arb_gnt == GNT_D) begin
            w_ram_addr_d = bus.d_addr[ADDR_WIDTH+1:2];
            w_ram_we_d   = bus.d_wen ? bus.d_be : '0;
          end else begin
            w_ram_addr_d = bus.i_addr[ADDR_WIDTH+1:2];
          end
        end
      end
      StWait: begin
        if (r_cnt == '0) begin
          w_state_d = StResp;
          if (r_gnt == GNT_D) begin
            w_d_ack_d   = 1'b1;
            w_d_rdata_d = ram_dout;
          end else begin
            w_i_ack_d   = 1'b1;
            w_i_rdata_d = ram_dout;
          end
        end else begin
          w_cnt_d = r_cnt - LAT_W'(1);
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign ram_en      = r_ram_en;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_din     = r_ram_din;

  assign bus.i_ack   = r_i_ack;
  assign bus.d_ack   = r_d_ack;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;
  assign bus.i_stall = bus.i_req & ~r_i_ack;
  assign bus.d_stall = bus.d_req & ~r_d_ack;

endmodule
